// File: rtl/mem_bist_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bist_pkg : shared types, defaults and pattern function          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_bist_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_ERR_W      = 16;

  // Wide enough for any practical data width; callers truncate the result.
  localparam int PAT_W = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    DONE     = 3'd5
  } bist_state_e;

  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                           input logic [PAT_W-1:0] idx);
    return seed + idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_timeout_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | bist_timeout_ctr : load/enable counter, expired on the TIMEOUT-th   |
// | enabled cycle after a load.                     Rev 1.0             |
// +--------------------------------------------------------------------+
module bist_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bist_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bist_master : write seed+index pattern over a window, read it   |
// | back and compare; reports pass, errors and ready timeout. Rev 1.0   |
// +--------------------------------------------------------------------+
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [WIDTH-1:0]      seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  output logic                  m_wr_rd,
  output logic                  m_valid,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready
);

  localparam int IW = ADDR_WIDTH + 1;

  bist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]         len_q, len_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [IW-1:0]         index_q, index_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  tmo_q, tmo_d;
  logic                  pass_q, pass_d;

  logic                  is_issue, is_wait, tmo_expired, last_word, mismatch;
  logic [IW-1:0]         adv_idx;
  logic [ADDR_WIDTH-1:0] adv_addr;
  logic [WIDTH-1:0]      adv_data, rd_expect;

  assign is_issue  = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
  assign is_wait   = (state_q == WR_WAIT)  || (state_q == RD_WAIT);
  assign last_word = ((index_q + IW'(1)) == len_q);

  // Index/address/data of the next word, wrapping to the window start after the last one.
  assign adv_idx   = last_word ? '0 : (index_q + IW'(1));
  assign adv_addr  = base_q + adv_idx[ADDR_WIDTH-1:0];
  assign adv_data  = WIDTH'(pat(PAT_W'(seed_q), PAT_W'(adv_idx)));
  assign rd_expect = WIDTH'(pat(PAT_W'(seed_q), PAT_W'(index_q)));
  assign mismatch  = (m_rdata != rd_expect);

  bist_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (is_issue),
    .en      (is_wait),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    seed_d  = seed_q;
    index_d = index_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_rd_d = wr_rd_q;
    err_d   = err_q;
    first_d = first_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          seed_d  = seed;
          index_d = '0;
          addr_d  = base_addr;
          wdata_d = seed;
          wr_rd_d = 1'b1;
          err_d   = '0;
          first_d = '0;
          tmo_d   = 1'b0;
          pass_d  = 1'b0;
          state_d = (length == '0) ? DONE : WR_ISSUE;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      RD_ISSUE: state_d = RD_WAIT;
      WR_WAIT: begin
        if (m_ready) begin
          index_d = adv_idx;
          addr_d  = adv_addr;
          wdata_d = adv_data;
          if (last_word) begin
            wr_rd_d = 1'b0;
            state_d = RD_ISSUE;
          end else begin
            state_d = WR_ISSUE;
          end
        end else if (tmo_expired) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      RD_WAIT: begin
        if (m_ready) begin
          if (mismatch) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
              first_d = addr_q;
            end
          end
          if (last_word) begin
            state_d = DONE;
          end else begin
            index_d = adv_idx;
            addr_d  = adv_addr;
            wdata_d = adv_data;
            state_d = RD_ISSUE;
          end
        end else if (tmo_expired) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Verdict is formed on entry to DONE so it is valid alongside the done pulse.
    if ((state_d == DONE) && (state_q != DONE)) begin
      pass_d = (err_d == '0) && !tmo_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      index_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_rd_q <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_rd_q <= wr_rd_d;
      err_q   <= err_d;
      first_q <= first_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = is_issue || is_wait;
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign timeout_err    = tmo_q;
  assign m_addr         = addr_q;
  assign m_wdata        = wdata_q;
  assign m_wr_rd        = wr_rd_q;
  assign m_valid        = is_issue;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_bist_master : bench with a responding memory model and a     |
// | window-level reference for transactions and results.   Rev 1.0     |
// +--------------------------------------------------------------------+
module tb_mem_bist_master;

  localparam int AW = 8;
  localparam int W  = 32;
  localparam int TO = 16;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [W-1:0]  seed;
  logic          busy, done, pass, timeout_err;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata;
  logic          m_wr_rd, m_valid;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_bist_master #(
    .ADDR_WIDTH (AW),
    .WIDTH      (W),
    .TIMEOUT    (TO),
    .ERR_W      (EW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout_err    (timeout_err),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_wr_rd        (m_wr_rd),
    .m_valid        (m_valid),
    .m_rdata        (mem_rdata),
    .m_ready        (mem_ready)
  );

  // Memory model: registered ready/rdata, optional random extra latency and a read fault.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [W-1:0]  wdata;
  } txn_t;

  txn_t          log_q[$];
  logic [W-1:0]  mem [0:255];
  bit            never_ready = 1'b0;
  bit            delay_mode  = 1'b0;
  bit            fault_en    = 1'b0;
  logic [AW-1:0] fault_addr  = '0;
  int            rand_dly    = 0;
  bit            p_pend      = 1'b0;
  int            p_dly       = 0;
  logic [AW-1:0] p_addr      = '0;
  bit            prev_v      = 1'b0;
  int            dbl_cnt     = 0;

  int total = 0;
  int bad   = 0;
  int mark  = 0;

  function automatic logic [W-1:0] rd_val(input logic [AW-1:0] a);
    return mem[a] ^ {{(W-1){1'b0}}, (fault_en && (a == fault_addr))};
  endfunction

  always @(posedge clk) begin
    rand_dly  <= delay_mode ? int'($urandom_range(3, 0)) : 0;
    mem_ready <= 1'b0;
    prev_v    <= m_valid;
    if (m_valid && prev_v) dbl_cnt <= dbl_cnt + 1;
    if (m_valid) begin
      log_q.push_back({m_addr, m_wr_rd, m_wdata});
      if (m_wr_rd) mem[m_addr] <= m_wdata;
      if (!never_ready) begin
        if (rand_dly == 0) begin
          mem_ready <= 1'b1;
          mem_rdata <= rd_val(m_addr);
        end else begin
          p_pend <= 1'b1;
          p_dly  <= rand_dly - 1;
          p_addr <= m_addr;
        end
      end
    end else if (p_pend) begin
      if (p_dly == 0) begin
        mem_ready <= 1'b1;
        mem_rdata <= rd_val(p_addr);
        p_pend    <= 1'b0;
      end else begin
        p_dly <= p_dly - 1;
      end
    end
  end

  // Reference: every word written in address order, then every word read back in the same order.
  function automatic int log_bad(input int from, input int b, input int len, input logic [W-1:0] sd);
    int n = 0;
    if (log_q.size() - from != 2 * len) return 1;
    for (int k = 0; k < 2 * len; k++) begin
      int i = k % len;
      txn_t t = log_q[from + k];
      if (t.addr !== AW'(b + i) || t.wr !== (k < len) || t.wdata !== sd + W'(i)) n++;
    end
    return n;
  endfunction

  function automatic int exp_errs(input int b, input int len);
    int n = 0;
    for (int i = 0; i < len; i++) if (fault_en && AW'(b + i) == fault_addr) n++;
    return n;
  endfunction

  function automatic logic [AW-1:0] exp_first(input int b, input int len);
    for (int i = 0; i < len; i++) if (fault_en && AW'(b + i) == fault_addr) return AW'(b + i);
    return '0;
  endfunction

  task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] l, input logic [W-1:0] s);
    @(negedge clk);
    base_addr = b;
    length    = l;
    seed      = s;
    start     = 1'b1;
    mark      = log_q.size();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n = cycle (counted from the start edge) in which done is seen high.
  task automatic wait_done(input int inj_at, output int n, output bit ok);
    n  = 1;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (k == inj_at) begin
        start     = 1'b1;
        base_addr = 8'hC0;
        length    = 9'd3;
        seed      = ~seed;
      end
      @(posedge clk);
      #1 start = 1'b0;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({m_valid, m_wr_rd, busy, done, pass, timeout_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {m_valid, m_wr_rd, busy, done, pass, timeout_err});
    end
    total++; if (m_addr !== '0 || m_wdata !== '0) begin
      bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", m_addr, m_wdata);
    end
    total++; if (err_count !== '0 || first_err_addr !== '0) begin
      bad++; $display("FAIL reset_err: got err=%0d first=%h want 0", err_count, first_err_addr);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic;
    int n; bit ok; int mb = 0;
    start_run(8'h10, 9'd4, 32'hA000_0000);
    wait_done(-1, n, ok);
    total++; if (!ok || n !== 17) begin bad++; $display("FAIL basic_latency: got %0d want 17", n); end
    total++; if (pass !== 1'b1 || err_count !== '0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL basic_result: got pass=%b err=%0d tmo=%b want 1 0 0", pass, err_count, timeout_err);
    end
    total++; if (log_bad(mark, 16, 4, 32'hA000_0000) !== 0) begin
      bad++; $display("FAIL basic_txns: got %0d bad txns want 0", log_bad(mark, 16, 4, 32'hA000_0000));
    end
    for (int i = 0; i < 4; i++) if (mem[AW'(16 + i)] !== 32'hA000_0000 + W'(i)) mb++;
    total++; if (mb !== 0) begin bad++; $display("FAIL basic_mem: got %0d bad words want 0", mb); end
  endtask

  task automatic test_wrap;
    int n; bit ok; logic [W-1:0] s = $urandom;
    start_run(8'hFE, 9'd4, s);
    wait_done(-1, n, ok);
    total++; if (log_bad(mark, 254, 4, s) !== 0) begin
      bad++; $display("FAIL wrap_txns: got %0d bad txns want 0", log_bad(mark, 254, 4, s));
    end
    total++; if (!ok || pass !== 1'b1) begin bad++; $display("FAIL wrap_pass: got %b want 1", pass); end
  endtask

  task automatic test_fault;
    int n; bit ok; logic [W-1:0] s = $urandom;
    fault_en   = 1'b1;
    fault_addr = 8'h12;
    start_run(8'h10, 9'd8, s);
    wait_done(-1, n, ok);
    total++; if (!ok || err_count !== 16'd1 || first_err_addr !== 8'h12) begin
      bad++; $display("FAIL fault_err: got err=%0d first=%h want 1 12", err_count, first_err_addr);
    end
    total++; if (pass !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL fault_pass: got pass=%b tmo=%b want 0 0", pass, timeout_err);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_timeout;
    int n; bit ok;
    never_ready = 1'b1;
    start_run(8'h30, 9'd2, 32'h1234_5678);
    wait_done(-1, n, ok);
    total++; if (!ok || n < TO + 1 || n > TO + 3) begin
      bad++; $display("FAIL tmo_latency: got %0d want %0d..%0d", n, TO + 1, TO + 3);
    end
    total++; if (timeout_err !== 1'b1 || pass !== 1'b0) begin
      bad++; $display("FAIL tmo_flags: got tmo=%b pass=%b want 1 0", timeout_err, pass);
    end
    repeat (30) @(posedge clk);
    #1;
    total++; if (log_q.size() - mark !== 1) begin
      bad++; $display("FAIL tmo_valids: got %0d want 1", log_q.size() - mark);
    end
    never_ready = 1'b0;
  endtask

  task automatic test_len_zero;
    int n; bit ok;
    start_run(8'h33, 9'd0, 32'hDEAD_BEEF);
    wait_done(-1, n, ok);
    total++; if (!ok || n !== 1 || pass !== 1'b1) begin
      bad++; $display("FAIL len0: got n=%0d pass=%b want 1 1", n, pass);
    end
    total++; if (log_q.size() - mark !== 0) begin
      bad++; $display("FAIL len0_valids: got %0d want 0", log_q.size() - mark);
    end
  endtask

  task automatic test_start_while_busy;
    int n; bit ok; logic [W-1:0] s = $urandom;
    start_run(8'h20, 9'd6, s);
    wait_done(5, n, ok);
    total++; if (!ok || n !== 25 || pass !== 1'b1 || err_count !== '0) begin
      bad++; $display("FAIL busy_start: got n=%0d pass=%b err=%0d want 25 1 0", n, pass, err_count);
    end
    total++; if (log_bad(mark, 32, 6, s) !== 0) begin
      bad++; $display("FAIL busy_txns: got %0d bad txns want 0", log_bad(mark, 32, 6, s));
    end
  endtask

  task automatic test_reset_mid_read;
    int n; bit ok; int seen = 0; int mk;
    logic [W-1:0] s = $urandom;
    start_run(8'h40, 9'd8, s);
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (log_q.size() - mark >= 10) seen = 1;
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL rstmid_reach: got %0d want 1", seen); end
    #2 rst = 1'b1;
    #1;
    total++; if ({m_valid, busy, done, m_wr_rd, pass} !== 5'b0 || m_addr !== '0 || m_wdata !== '0 || err_count !== '0) begin
      bad++; $display("FAIL rstmid_outs: got v=%b busy=%b addr=%h wdata=%h want 0", m_valid, busy, m_addr, m_wdata);
    end
    mk = log_q.size();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (log_q.size() !== mk) begin
      bad++; $display("FAIL rstmid_quiet: got %0d extra valids want 0", log_q.size() - mk);
    end
    s = $urandom;
    start_run(8'h40, 9'd8, s);
    wait_done(-1, n, ok);
    total++; if (!ok || n !== 33 || pass !== 1'b1 || log_bad(mark, 64, 8, s) !== 0) begin
      bad++; $display("FAIL rstmid_rerun: got n=%0d pass=%b want 33 1", n, pass);
    end
  endtask

  task automatic test_random;
    int n; bit ok; int e;
    logic [AW-1:0] b; logic [AW:0] l; logic [W-1:0] s; logic [AW-1:0] ef;
    delay_mode = 1'b1;
    for (int r = 0; r < 8; r++) begin
      b          = AW'($urandom);
      l          = (AW + 1)'($urandom_range(40, 1));
      s          = $urandom;
      fault_en   = 1'($urandom_range(1, 0));
      fault_addr = b + AW'($urandom_range(45, 0));
      e          = exp_errs(int'(b), int'(l));
      ef         = exp_first(int'(b), int'(l));
      start_run(b, l, s);
      wait_done(-1, n, ok);
      total++; if (!ok || err_count !== EW'(e) || first_err_addr !== ef) begin
        bad++; $display("FAIL rand%0d_err: got err=%0d first=%h want %0d %h", r, err_count, first_err_addr, e, ef);
      end
      total++; if (pass !== (e == 0) || timeout_err !== 1'b0) begin
        bad++; $display("FAIL rand%0d_pass: got pass=%b tmo=%b want %b 0", r, pass, timeout_err, (e == 0));
      end
      total++; if (log_bad(mark, int'(b), int'(l), s) !== 0) begin
        bad++; $display("FAIL rand%0d_txns: got %0d bad txns want 0", r, log_bad(mark, int'(b), int'(l), s));
      end
    end
    delay_mode = 1'b0;
    fault_en   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    seed      = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_timeout();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_read();
    test_random();
    total++; if (dbl_cnt !== 0) begin
      bad++; $display("FAIL back_to_back_valid: got %0d want 0", dbl_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
